// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
// Register addresses are carried zero-extended to RA_W_MAX inside pending entries.
package hazard_pkg;

    localparam int RA_W_DEF = 5;
    localparam int RA_W_MAX = 16;
    localparam int CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                load;
    } pend_entry_t;

    function automatic pend_entry_t make_entry(input logic [RA_W_MAX-1:0] rd, input logic load);
        pend_entry_t e;
        e.valid = 1'b1;
        e.rd    = rd;
        e.load  = load;
        return e;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one pending destination against both ID source operands.
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic                entry_valid,
    input  logic [RA_W_MAX-1:0] entry_rd,
    input  logic [RA_W_MAX-1:0] rs,
    input  logic [RA_W_MAX-1:0] rt,
    input  logic                rs_used,
    input  logic                rt_used,
    output logic                match
);

    assign match = entry_valid &&
                   ((rs_used && (entry_rd == rs)) || (rt_used && (entry_rd == rt)));

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of in-flight instructions and stalls ID on a read-after-write
// dependence (any pending write, or load-use only when forwarding exists).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned RA_W  = RA_W_DEF,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned FWD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             Ctrl_Mux,
    output logic [CNT_W-1:0] stall_cycles
);

    pend_entry_t         pend_r [DEPTH];
    logic [CNT_W-1:0]    stall_cnt_r;
    logic [DEPTH-1:0]    match_s;
    logic                hazard_s;
    logic                issue_s;
    logic [RA_W_MAX-1:0] rs_ext_s;
    logic [RA_W_MAX-1:0] rt_ext_s;
    logic [RA_W_MAX-1:0] rd_ext_s;

    assign rs_ext_s = RA_W_MAX'(id_rs);
    assign rt_ext_s = RA_W_MAX'(id_rt);
    assign rd_ext_s = RA_W_MAX'(id_rd);

    for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
        hazard_cmp u_cmp (
            .entry_valid (pend_r[g].valid),
            .entry_rd    (pend_r[g].rd),
            .rs          (rs_ext_s),
            .rt          (rt_ext_s),
            .rs_used     (id_rs_used),
            .rt_used     (id_rt_used),
            .match       (match_s[g])
        );
    end

    // Reduce per-stage matches to a stall request; a flush squashes ID so it never stalls.
    always_comb begin
        hazard_s = 1'b0;
        if (id_valid && !flush) begin
            if (FWD != 0) begin
                hazard_s = match_s[0] && pend_r[0].load;
            end else begin
                hazard_s = |match_s;
            end
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Decide whether the ID instruction enters the scoreboard this edge.
    always_comb begin
        issue_s = 1'b0;
        if (id_valid && !hazard_s && !flush && id_wr_en && (id_rd != '0)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Advance the pending pipeline and accumulate the saturating stall count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pend_r[k] <= '0;
            end
            stall_cnt_r <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                pend_r[k] <= pend_r[k-1];
            end
            if (issue_s) begin
                pend_r[0] <= make_entry(rd_ext_s, id_is_load);
            end else begin
                pend_r[0] <= '0;
            end
            if (hazard_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
        end
    end

    assign PC_en        = !hazard_s;
    assign IF_ID_en     = !hazard_s;
    assign Ctrl_Mux     = !hazard_s;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: four configurations driven from shared inputs,
// each scenario checked on the instance it targets.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        id_wr_en;
    logic [4:0]  id_rd;
    logic        id_is_load;
    logic        flush;

    logic        pc_en [4];
    logic        ifid  [4];
    logic        ctrl  [4];
    logic [15:0] cnt   [4];

    int n_cmp;
    int n_err;
    int n_stall;

    hazard_scoreboard #(.DEPTH(2), .FWD(0)) u_d2f0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
        .PC_en(pc_en[0]), .IF_ID_en(ifid[0]), .Ctrl_Mux(ctrl[0]), .stall_cycles(cnt[0]));

    hazard_scoreboard #(.DEPTH(2), .FWD(1)) u_d2f1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
        .PC_en(pc_en[1]), .IF_ID_en(ifid[1]), .Ctrl_Mux(ctrl[1]), .stall_cycles(cnt[1]));

    hazard_scoreboard #(.DEPTH(3), .FWD(0)) u_d3f0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
        .PC_en(pc_en[2]), .IF_ID_en(ifid[2]), .Ctrl_Mux(ctrl[2]), .stall_cycles(cnt[2]));

    hazard_scoreboard #(.DEPTH(8), .FWD(0)) u_d8f0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
        .PC_en(pc_en[3]), .IF_ID_en(ifid[3]), .Ctrl_Mux(ctrl[3]), .stall_cycles(cnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic rsu,
                          input logic [4:0] rt, input logic rtu,
                          input logic wr, input logic [4:0] rd, input logic ld);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_wr_en   = wr;
        id_rd      = rd;
        id_is_load = ld;
        #1;
    endtask

    task automatic do_reset();
        flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [2:0] outs(input int i);
        return {pc_en[i], ifid[i], ctrl[i]};
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        flush = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("reset_outs", 32'(outs(i)), 32'h7);
            check_eq("reset_cnt", 32'(cnt[i]), 32'h0);
        end

        // Write rd=5 then read rs=5: two stall cycles with DEPTH=2, FWD=0
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        check_eq("raw_producer_issue", 32'(outs(0)), 32'h7);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_eq("raw_stall1", 32'(outs(0)), 32'h0);
        tick();
        check_eq("raw_stall2", 32'(outs(0)), 32'h0);
        tick();
        check_eq("raw_issue3", 32'(outs(0)), 32'h7);
        check_eq("raw_cnt", 32'(cnt[0]), 32'd2);

        // Register 0 never creates a dependence
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_eq("r0_no_stall", 32'(outs(0)), 32'h7);
        tick();
        check_eq("r0_cnt", 32'(cnt[0]), 32'd0);

        // Forwarding: load-use stalls once, a plain ALU producer does not
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0);
        check_eq("ldu_stall", 32'(outs(1)), 32'h0);
        tick();
        check_eq("ldu_issue", 32'(outs(1)), 32'h7);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0);
        check_eq("alu_fwd_no_stall", 32'(outs(1)), 32'h7);
        tick();
        check_eq("fwd_cnt", 32'(cnt[1]), 32'd1);

        // Flush overrides a stall and bubbles entry 0 while older entries keep shifting
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        tick();
        flush = 1'b1;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0);
        check_eq("flush_outs", 32'(outs(2)), 32'h7);
        tick();
        flush = 1'b0;
        check_eq("flush_e0_bubble", 32'(u_d3f0.pend_r[0].valid), 32'h0);
        check_eq("flush_e1_valid", 32'(u_d3f0.pend_r[1].valid), 32'h1);
        check_eq("flush_e1_rd", 32'(u_d3f0.pend_r[1].rd), 32'd7);
        check_eq("flush_cnt", 32'(cnt[2]), 32'd0);

        // Same dependence without flush stalls DEPTH=3 cycles
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        n_stall = 0;
        while ((pc_en[2] == 1'b0) && (n_stall < 6)) begin
            n_stall++;
            tick();
        end
        check_eq("d3_stall_len", 32'(n_stall), 32'd3);
        check_eq("d3_cnt", 32'(cnt[2]), 32'd3);

        // Reset pulsed mid-stall discards pending entries and clears the counter
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        check_eq("mid_stall", 32'(outs(0)), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_outs", 32'(outs(0)), 32'h7);
        check_eq("rst_mid_cnt", 32'(cnt[0]), 32'd0);
        check_eq("rst_mid_e0", 32'(u_d2f0.pend_r[0].valid), 32'h0);
        check_eq("rst_mid_e1", 32'(u_d2f0.pend_r[1].valid), 32'h0);

        // Self-dependent stream on DEPTH=8: 8 stall cycles per issue, counter saturates
        do_reset();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
        repeat (1 + 9 * 100) tick();
        check_eq("sat_mid_cnt", 32'(cnt[3]), 32'd800);
        repeat (9 * 8100) tick();
        check_eq("sat_cnt", 32'(cnt[3]), 32'hFFFF);
        repeat (20) tick();
        check_eq("sat_hold", 32'(cnt[3]), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter RA_W, default 5, sets the register address width.
REQ-002 Parameter DEPTH, default 2, sets the number of tracked in-flight stages between ID and WB (range 1..8).
REQ-003 Parameter FWD, default 0, selects the stall mode: 0 = stall on any pending write; 1 = forwarding present, so stall on load-use only.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port id_valid, input, 1 bit: the IF/ID register holds a real instruction.
REQ-007 Ports id_rs and id_rt, input, RA_W bits each: the ID source register addresses.
REQ-008 Ports id_rs_used and id_rt_used, input, 1 bit each: the corresponding source is actually read.
REQ-009 Port id_wr_en, input, 1 bit: the ID instruction writes the register file.
REQ-010 Port id_rd, input, RA_W bits: the resolved destination, already selected by RegDst.
REQ-011 Port id_is_load, input, 1 bit: the ID instruction is a load.
REQ-012 Port flush, input, 1 bit: squash the ID instruction (taken branch or jump).
REQ-013 Ports PC_en, IF_ID_en and Ctrl_Mux, output, 1 bit each: 1 = advance; 0 = hold PC and IF/ID and inject a bubble.
REQ-014 Port stall_cycles, output, 16 bits: saturating count of stall cycles.

Function
REQ-015 The block SHALL hold a DEPTH-entry pending shift register; each entry holds {valid, rd[RA_W], load}; entry 0 is the youngest.
REQ-016 On each rising edge, entry k (k>0) SHALL load entry k-1, and entry DEPTH-1 SHALL be discarded.
REQ-017 On the same edge, entry 0 SHALL load {1, id_rd, id_is_load} only when id_valid, !hazard, !flush, id_wr_en and id_rd != 0 all hold; otherwise entry 0 SHALL load an invalid entry (bubble).
REQ-018 A source match SHALL mean a valid entry whose rd equals id_rs with id_rs_used=1, or equals id_rt with id_rt_used=1.
REQ-019 Register 0 SHALL never match, because entries are never created for rd = 0.
REQ-020 When FWD=0, hazard SHALL be id_valid and a source match in any of the DEPTH entries.
REQ-021 When FWD=1, hazard SHALL be id_valid and a source match in entry 0 with load=1 only.
REQ-022 PC_en, IF_ID_en and Ctrl_Mux SHALL each equal !hazard, combinationally in the same cycle, with zero latency.
REQ-023 flush=1 SHALL force hazard=0 for that cycle; flush wins over a simultaneous stall.
REQ-024 flush=1 SHALL leave entries 1..DEPTH-1 shifting normally, since those instructions are older than the branch.
REQ-025 id_valid=0 SHALL produce no hazard and a bubble into entry 0.
REQ-026 stall_cycles SHALL increment by 1 on each edge where hazard=1 and hold at 16'hFFFF once reached, with no wrap.
REQ-027 A stalled instruction SHALL re-evaluate every cycle and SHALL issue on the first cycle with no match, so the maximum stall is DEPTH cycles.

Reset
REQ-028 When rst=1 at a rising edge, all entries SHALL become invalid and stall_cycles SHALL become 0.
REQ-029 In the cycle after a reset edge, all entries are invalid, so hazard=0 and PC_en = IF_ID_en = Ctrl_Mux = 1 until the next instruction issues.
REQ-030 Reset asserted mid-stall SHALL discard all pending entries; no issue is recorded on the reset edge.
REQ-031 The block SHALL use no initial blocks for functional state.

Structure
REQ-032 Package hazard_pkg SHALL hold the pending-entry struct type (valid, rd, load), the RA_W default and the counter width constant (16).
REQ-033 Sub-module hazard_cmp SHALL compare one entry against both sources, output a match bit, and be instantiated DEPTH times.
REQ-034 The top level SHALL reduce the match bits to hazard according to FWD.
REQ-035 The expected size is roughly 150-250 lines of RTL.

Verification
REQ-036 DEPTH=2, FWD=0: issue wr rd=5, then ID rs=5 used -> hazard for exactly 2 cycles, issue in the 3rd cycle, stall_cycles=2.
REQ-037 DEPTH=2, FWD=0: issue wr rd=0, then ID rs=0 used -> no stall; the outputs stay 1.
REQ-038 DEPTH=2, FWD=1: load rd=8, then ID rt=8 used -> exactly 1 stall cycle. Non-load rd=8, then rt=8 -> 0 stall cycles.
REQ-039 DEPTH=3, FWD=0: rd=7 pending in entry 0 and ID rs=7 with flush=1 -> the outputs are 1 that cycle and entry 0 is invalid next cycle. Without flush the stall would be 3 cycles.
REQ-040 A stall is in progress and rst is pulsed for 1 cycle -> on the next cycle the outputs are 1, stall_cycles=0 and all entries are invalid.
REQ-041 Hazard held continuously for 65540 cycles -> stall_cycles=16'hFFFF, and it stays there.
